// File: rtl/load_store_unit.sv
// Load/store unit between the core and a word-wide data memory without byte enables; SB/SH use read-modify-write.
// Optional define LSU_MISALIGN_TRAP_EN: flag and suppress misaligned H/W accesses instead of clearing low address bits.
module load_store_unit #(
    parameter int ADDR_W     = 32,
    parameter int DMEM_WORDS = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       store_data_i,
    output logic [31:0]       load_data_o,
    output logic              stall_o,
    output logic              misaligned_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [31:0]       dmem_wd_o,
    output logic              dmem_we_o,
    input  logic [31:0]       dmem_rd_i
);

    typedef enum logic {IDLE, MERGE} state_t;

    localparam logic [ADDR_W-3:0] WORDS_LIM = (ADDR_W-2)'(DMEM_WORDS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [31:0]       lat_data_q, lat_data_d;
    logic [2:0]        lat_size_q, lat_size_d;
    logic [31:0]       rmw_word_q, rmw_word_d;

    logic              f3_b, f3_h, f3_w, f3_bu, f3_hu;
    logic              legal_ld, mis, oor;
    logic [ADDR_W-1:0] addr_eff;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [4:0]        mrg_sh;
    logic [31:0]       mrg_mask, mrg_word;

    assign f3_b     = (funct3_i == 3'b000);
    assign f3_h     = (funct3_i == 3'b001);
    assign f3_w     = (funct3_i == 3'b010);
    assign f3_bu    = (funct3_i == 3'b100);
    assign f3_hu    = (funct3_i == 3'b101);
    assign legal_ld = f3_b | f3_h | f3_w | f3_bu | f3_hu;

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis      = ((f3_h | f3_hu) & addr_i[0]) | (f3_w & (addr_i[1:0] != 2'b00));
    assign addr_eff = addr_i;
`else
    assign mis = 1'b0;
    always_comb begin
        addr_eff = addr_i;
        if (f3_h | f3_hu) addr_eff[0] = 1'b0;
        if (f3_w)         addr_eff[1:0] = 2'b00;
    end
`endif

    assign oor = (addr_i[ADDR_W-1:2] >= WORDS_LIM);

    always_comb begin
        case (addr_eff[1:0])
            2'd0:    ld_byte = dmem_rd_i[7:0];
            2'd1:    ld_byte = dmem_rd_i[15:8];
            2'd2:    ld_byte = dmem_rd_i[23:16];
            default: ld_byte = dmem_rd_i[31:24];
        endcase
    end
    assign ld_half = addr_eff[1] ? dmem_rd_i[31:16] : dmem_rd_i[15:0];

    // Lane insertion for the second RMW cycle: byte lane for SB, half lane for SH.
    assign mrg_sh   = (lat_size_q == 3'b000) ? {lat_addr_q[1:0], 3'b000} : {lat_addr_q[1], 4'b0000};
    assign mrg_mask = ((lat_size_q == 3'b000) ? 32'h0000_00FF : 32'h0000_FFFF) << mrg_sh;
    assign mrg_word = (rmw_word_q & ~mrg_mask) | ((lat_data_q << mrg_sh) & mrg_mask);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lat_addr_q <= '0;
            lat_data_q <= '0;
            lat_size_q <= '0;
            rmw_word_q <= '0;
        end else begin
            state_q    <= state_d;
            lat_addr_q <= lat_addr_d;
            lat_data_q <= lat_data_d;
            lat_size_q <= lat_size_d;
            rmw_word_q <= rmw_word_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lat_addr_d   = lat_addr_q;
        lat_data_d   = lat_data_q;
        lat_size_d   = lat_size_q;
        rmw_word_d   = rmw_word_q;
        load_data_o  = 32'h0;
        stall_o      = 1'b0;
        misaligned_o = 1'b0;
        dmem_addr_o  = {addr_eff[ADDR_W-1:2], 2'b00};
        dmem_wd_o    = store_data_i;
        dmem_we_o    = 1'b0;
        case (state_q)
            IDLE: begin
                misaligned_o = (mem_read_i | mem_write_i) & mis;
                if (mem_write_i) begin
                    if (!oor && !mis) begin
                        if (f3_w) begin
                            dmem_we_o = 1'b1;
                        end else if (f3_b | f3_h) begin
                            stall_o    = 1'b1;
                            state_d    = MERGE;
                            lat_addr_d = addr_eff;
                            lat_data_d = store_data_i;
                            lat_size_d = funct3_i;
                            rmw_word_d = dmem_rd_i;
                        end
                    end
                end else if (mem_read_i && legal_ld && !oor && !mis) begin
                    case (funct3_i)
                        3'b000:  load_data_o = {{24{ld_byte[7]}}, ld_byte};
                        3'b001:  load_data_o = {{16{ld_half[15]}}, ld_half};
                        3'b100:  load_data_o = {24'h0, ld_byte};
                        3'b101:  load_data_o = {16'h0, ld_half};
                        default: load_data_o = dmem_rd_i;
                    endcase
                end
            end
            MERGE: begin
                dmem_addr_o = {lat_addr_q[ADDR_W-1:2], 2'b00};
                dmem_wd_o   = mrg_word;
                dmem_we_o   = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset dominates everything, including an in-flight MERGE write.
        if (rst_i) begin
            load_data_o  = 32'h0;
            stall_o      = 1'b0;
            misaligned_o = 1'b0;
            dmem_we_o    = 1'b0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural word memory and write/load scoreboards.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [31:0] load_data;
    logic        stall, misaligned;
    logic [31:0] dmem_addr, dmem_wd, dmem_rd;
    logic        dmem_we;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:63];
    logic [63:0] exp_wr [$];
    logic [31:0] exp_ld [$];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DMEM_WORDS(64)) dut (
        .clk_i(clk), .rst_i(rst),
        .mem_read_i(mem_read), .mem_write_i(mem_write),
        .funct3_i(funct3), .addr_i(addr), .store_data_i(store_data),
        .load_data_o(load_data), .stall_o(stall), .misaligned_o(misaligned),
        .dmem_addr_o(dmem_addr), .dmem_wd_o(dmem_wd), .dmem_we_o(dmem_we),
        .dmem_rd_i(dmem_rd)
    );

    // Memory aliases out-of-range words so the DUT, not the model, must produce zero.
    assign dmem_rd = mem[6'(dmem_addr >> 2)];
    always @(posedge clk) if (dmem_we) mem[6'(dmem_addr >> 2)] <= dmem_wd;

    always @(negedge clk) begin
        if (dmem_we) begin
            logic [63:0] e;
            checks++;
            if (exp_wr.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%h data=%h", dmem_addr, dmem_wd);
            end else begin
                e = exp_wr.pop_front();
                if ({dmem_addr, dmem_wd} !== e) begin
                    failures++;
                    $display("FAIL write addr/data got=%h_%h exp=%h_%h", dmem_addr, dmem_wd, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic load_check(input string name, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] expv);
        logic [31:0] e;
        exp_ld.push_back(expv);
        drive(1'b1, 1'b0, f3, a, 32'h0);
        @(negedge clk);
        e = exp_ld.pop_front();
        checks++;
        if (load_data !== e) begin
            failures++;
            $display("FAIL %s load_data got=%h exp=%h", name, load_data, e);
        end
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL %s stall got=%b exp=0", name, stall);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem[4] = 32'h8899_AABB;
        mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h10; store_data = 32'h0;
        @(negedge clk);
        checks++;
        if (load_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_load_data got=%h exp=00000000", load_data);
        end
        mem_read = 1'b0; mem_write = 1'b1; store_data = 32'h1111_2222;
        @(negedge clk);
        checks++;
        if ({stall, dmem_we, misaligned} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs stall/we/mis got=%b exp=000", {stall, dmem_we, misaligned});
        end
        rst = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [5];
        logic [31:0] as   [5];
        logic [31:0] exps [5];
        mem[4] = 32'h8899_AABB;
        f3s  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        as   = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10};
        exps = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899, 32'h0000_8899, 32'h8899_AABB};
        for (int i = 0; i < 5; i++) load_check($sformatf("load%0d", i), f3s[i], as[i], exps[i]);
        mem[63] = 32'hA5A5_0F0F;
        load_check("load_last_word", 3'b010, 32'hFC, 32'hA5A5_0F0F);
        load_check("load_byte0_pos", 3'b000, 32'hFC, 32'h0000_000F);
        idle();
    endtask

    task automatic test_sw();
        exp_wr.push_back({32'h10, 32'hDEAD_BEEF});
        drive(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if ({dmem_we, stall} !== 2'b10) begin
            failures++;
            $display("FAIL sw we/stall got=%b exp=10", {dmem_we, stall});
        end
        load_check("sw_readback", 3'b010, 32'h10, 32'hDEAD_BEEF);
        idle();
    endtask

    task automatic test_sb_rmw();
        mem[4] = 32'h8899_AABB;
        exp_wr.push_back({32'h10, 32'hC399_AABB});
        drive(1'b0, 1'b1, 3'b000, 32'h13, 32'h1234_56C3);
        @(negedge clk);
        checks++;
        if ({stall, dmem_we} !== 2'b10) begin
            failures++;
            $display("FAIL sb_cycle0 stall/we got=%b exp=10", {stall, dmem_we});
        end
        @(negedge clk);
        checks++;
        if ({stall, dmem_we, dmem_wd} !== {2'b01, 32'hC399_AABB}) begin
            failures++;
            $display("FAIL sb_cycle1 stall/we/wd got=%b%b_%h exp=01_c399aabb", stall, dmem_we, dmem_wd);
        end
        load_check("sb_readback", 3'b010, 32'h10, 32'hC399_AABB);
        idle();
    endtask

    task automatic test_sh_misaligned();
        mem[4] = 32'h8899_AABB;
`ifdef LSU_MISALIGN_TRAP_EN
        drive(1'b0, 1'b1, 3'b001, 32'h11, 32'h0000_BEEF);
        @(negedge clk);
        checks++;
        if ({misaligned, stall, dmem_we} !== 3'b100) begin
            failures++;
            $display("FAIL sh_trap mis/stall/we got=%b exp=100", {misaligned, stall, dmem_we});
        end
        load_check("sh_trap_unchanged", 3'b010, 32'h10, 32'h8899_AABB);
`else
        exp_wr.push_back({32'h10, 32'h8899_BEEF});
        drive(1'b0, 1'b1, 3'b001, 32'h11, 32'h0000_BEEF);
        @(negedge clk);
        checks++;
        if ({misaligned, stall, dmem_we} !== 3'b010) begin
            failures++;
            $display("FAIL sh_cycle0 mis/stall/we got=%b exp=010", {misaligned, stall, dmem_we});
        end
        @(negedge clk);
        load_check("sh_readback", 3'b010, 32'h10, 32'h8899_BEEF);
`endif
        idle();
    endtask

    task automatic test_rst_merge();
        mem[4] = 32'h8899_AABB;
        drive(1'b0, 1'b1, 3'b000, 32'h10, 32'h0000_0077);
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL rstm_cycle0 stall got=%b exp=1", stall);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({dmem_we, stall} !== 2'b00) begin
            failures++;
            $display("FAIL rstm_abort we/stall got=%b exp=00", {dmem_we, stall});
        end
        @(negedge clk);
        rst = 1'b0;
        mem_write = 1'b0;
        load_check("rstm_unchanged", 3'b010, 32'h10, 32'h8899_AABB);
        exp_wr.push_back({32'h14, 32'h0BAD_F00D});
        drive(1'b0, 1'b1, 3'b010, 32'h14, 32'h0BAD_F00D);
        @(negedge clk);
        checks++;
        if ({dmem_we, stall, dmem_addr} !== {2'b10, 32'h14}) begin
            failures++;
            $display("FAIL rstm_idle we/stall/addr got=%b%b_%h exp=10_00000014", dmem_we, stall, dmem_addr);
        end
        idle();
    endtask

    task automatic test_out_of_range();
        mem[0] = 32'h1234_5678;
        drive(1'b0, 1'b1, 3'b010, 32'h100, 32'h5555_AAAA);
        @(negedge clk);
        checks++;
        if ({dmem_we, stall} !== 2'b00) begin
            failures++;
            $display("FAIL oor_sw we/stall got=%b exp=00", {dmem_we, stall});
        end
        load_check("oor_lw", 3'b010, 32'h100, 32'h0);
        load_check("oor_readback_w0", 3'b010, 32'h0, 32'h1234_5678);
        idle();
    endtask

    task automatic test_illegal_and_both();
        mem[4] = 32'h8899_AABB;
        load_check("illegal_ld_011", 3'b011, 32'h10, 32'h0);
        load_check("illegal_ld_110", 3'b110, 32'h10, 32'h0);
        drive(1'b0, 1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF);
        @(negedge clk);
        checks++;
        if ({dmem_we, stall} !== 2'b00) begin
            failures++;
            $display("FAIL illegal_st we/stall got=%b exp=00", {dmem_we, stall});
        end
        exp_wr.push_back({32'h18, 32'hCAFE_F00D});
        drive(1'b1, 1'b1, 3'b010, 32'h18, 32'hCAFE_F00D);
        @(negedge clk);
        checks++;
        if ({dmem_we, load_data} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL both_rw we/load_data got=%b_%h exp=1_00000000", dmem_we, load_data);
        end
        idle();
        @(negedge clk);
        checks++;
        if ({dmem_we, stall, load_data} !== {2'b00, 32'h0}) begin
            failures++;
            $display("FAIL no_req we/stall/load_data got=%b%b_%h exp=00_00000000", dmem_we, stall, load_data);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_loads();
        test_sw();
        test_sb_rmw();
        test_sh_misaligned();
        test_rst_merge();
        test_out_of_range();
        test_illegal_and_both();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_wr.size() != 0) begin
            failures++;
            $display("FAIL pending_writes got=%0d exp=0", exp_wr.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
